can_rx_packer: RTL and testbench
================================

CAN_RX_PACKER -- requirements
Module: can_rx_packer

Interface
REQ-001 Parameter ASIZE, default 6, log2 of the frame FIFO depth in 38-bit entries (64 entries).
REQ-002 Port clk, input, 1, system clock; one clock domain, all logic on its rising edge.
REQ-003 Port rstn, input, 1, asynchronous active-low reset; set to 1 while working.
REQ-004 Ports in_valid/in_last/in_data[7:0]/in_id[28:0]/in_ide, inputs, unbuffered CAN RX byte stream: one byte per in_valid cycle, in_last marks a frame's final byte; there is no backpressure.
REQ-005 Port out_valid, output, 1, FIFO head word is valid.
REQ-006 Port out_ready, input, 1, consumer accepts the word when out_valid=1 and out_ready=1.
REQ-007 Ports out_data[31:0]/out_keep[3:0]/out_hdr/out_last, outputs, head word, byte-valid mask, header-word flag and last-word-of-frame flag.
REQ-008 Port fifo_level[ASIZE:0], output, entries currently stored.
REQ-009 Port drop_cnt[15:0], output, saturating count of dropped frames.
REQ-010 Port drop_pulse, output, 1, one-cycle pulse per dropped frame.

Function
REQ-011 Staging: first in_valid byte of a frame latches in_id/in_ide; bytes are stored in order; byte count n is 1..8.
REQ-012 Bytes beyond the 8th are discarded, and the frame is marked oversize.
REQ-013 On in_valid and in_last, the staging content (id, ide, n, 64-bit bytes, oversize) is copied to commit registers in that cycle; staging clears so that a byte in the next cycle starts a new frame.
REQ-014 Frame format: header word = {ide, 2'b00, id[28:0]}, out_hdr=1, out_keep=4'b1111, out_last=0.
REQ-015 The header is followed by ceil(n/4) data words; the first byte goes in [31:24]; out_keep is MSB-aligned (n=1 gives 4'b1000); unused bytes are 0; the final data word has out_last=1.
REQ-016 Commit FSM states: IDLE, HDR, D0, D1; IDLE->HDR on commit request if accepted; HDR->D0; D0->D1 if n>4, else D0->IDLE; D1->IDLE; exactly one FIFO write per non-IDLE cycle.
REQ-017 Acceptance: the frame is accepted only if not oversize and free entries at request >= 1+ceil(n/4); whole frames only, never partial.
REQ-018 Drop: a rejected frame (oversize, insufficient space, or request while FSM not IDLE) is discarded.
REQ-019 Each drop pulses drop_pulse for 1 cycle and increments drop_cnt, saturating at 16'hFFFF.
REQ-020 Latency: in_last in cycle T puts the header on the output with out_valid=1 in cycle T+2 when the FIFO was empty.
REQ-021 FIFO is show-ahead: out_* hold stable while out_valid=1 and out_ready=0; a pop advances the head the next cycle.
REQ-022 Simultaneous push and pop leave fifo_level unchanged; full and empty are detected with an ASIZE+1-bit pointer wrap bit.
REQ-023 An in_valid byte with in_last=0 that arrives during commit is staged normally.
REQ-024 A zero-length frame produces no in_valid and is not observable; no entry is written for it.

Reset
REQ-025 rstn=0 clears, asynchronously: out_valid=0, out_data=0, out_keep=0, out_hdr=0, out_last=0, fifo_level=0, drop_cnt=0, drop_pulse=0; FSM=IDLE; staging and commit registers cleared.
REQ-026 Reset mid-frame or mid-commit discards the partial frame; no partial frame appears after reset release.

Structure
REQ-027 A shared constants include file holds: header bit positions (IDE=31, ID=28:0), FIFO entry width 38, and the FSM state encodings.
REQ-028 One sub-module can_rx_fifo holds the 38-bit synchronous show-ahead FIFO with ASIZE parameter, level output and BRAM-inferable storage; can_rx_packer holds staging, the FSM and drop logic.

Verification
REQ-029 Std frame, id=0x123, ide=0, 3 bytes AA BB CC -> header 0x00000123 hdr=1; then data 0xAABBCC00, keep=1110, last=1.
REQ-030 Ext frame, id=0x1ABCDEF0, ide=1, 8 bytes 01..08 -> header 0x9ABCDEF0; then 0x01020304 keep=1111 last=0; then 0x05060708 keep=1111 last=1.
REQ-031 out_ready=0 while pushing frames until fifo_level=62, then a 8-byte frame -> dropped, drop_pulse=1 for 1 cycle, drop_cnt=1, fifo_level stays 62.
REQ-032 10 bytes with in_last on the 10th -> frame dropped, drop_cnt+1, no FIFO write, next valid frame packed correctly.
REQ-033 rstn pulsed low after 2 of 5 bytes, then a full 1-byte frame 0x5A -> only that frame emitted: header, then 0x5A000000 keep=1000 last=1.
REQ-034 Random out_ready at 50% over 200 random frames -> output stream matches the reference model word-for-word, and no word changes while stalled.

Source files
------------

// File: rtl/can_rx_packer_pkg.sv
// can_rx_packer_pkg
//   Shared constants for the CAN RX packer.
//   - Header word bit positions (IDE flag, 29-bit identifier).
//   - FIFO entry layout: {hdr, last, keep[3:0], data[31:0]} = 38 bits.
//   - Commit FSM state encodings.
//   - keep_mask(): MSB-aligned byte-valid mask for a word holding 1..4 bytes.
package can_rx_packer_pkg;

  localparam int HDR_IDE_BIT  = 31;
  localparam int HDR_ID_MSB   = 28;
  localparam int HDR_ID_LSB   = 0;

  localparam int FIFO_W       = 38;
  localparam int ENT_HDR_BIT  = 37;
  localparam int ENT_LAST_BIT = 36;
  localparam int ENT_KEEP_MSB = 35;
  localparam int ENT_KEEP_LSB = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_D0   = 2'd2,
    ST_D1   = 2'd3
  } cmt_state_t;

  // Any count of 4 or more means a full word.
  function automatic logic [3:0] keep_mask(input logic [3:0] n_bytes);
    logic [3:0] m;
    case (n_bytes)
      4'd1:    m = 4'b1000;
      4'd2:    m = 4'b1100;
      4'd3:    m = 4'b1110;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/can_rx_packer_fifo.sv
// can_rx_fifo
//   Synchronous show-ahead FIFO of 38-bit frame entries.
//   Ports:
//     clk, rstn            clock, async active-low reset
//     i_wr_en, i_wr_data   push one entry (ignored when full)
//     i_rd_en              pop the head entry (ignored when empty)
//     o_valid, o_rd_data   head entry present / head entry (zero when empty)
//     o_level              entries stored, 0..2**ASIZE
//   Pointers carry one extra wrap bit so full and empty are distinguishable.
module can_rx_fifo
  import can_rx_packer_pkg::*;
#(
  parameter int ASIZE = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_wr_en,
  input  logic [FIFO_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic              o_valid,
  output logic [FIFO_W-1:0] o_rd_data,
  output logic [ASIZE:0]    o_level
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] PTR_INC = (ASIZE+1)'(1);

  logic [FIFO_W-1:0] r_mem [DEPTH];
  logic [ASIZE:0]    r_wr_ptr;
  logic [ASIZE:0]    r_rd_ptr;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ASIZE] != r_rd_ptr[ASIZE]) &&
                   (r_wr_ptr[ASIZE-1:0] == r_rd_ptr[ASIZE-1:0]);
  assign w_push  = i_wr_en && !w_full;
  assign w_pop   = i_rd_en && !w_empty;

  // Storage has no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[ASIZE-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_INC;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_INC;
    end
  end

  assign o_valid   = !w_empty;
  // Gated so the outputs read zero while empty, including straight after reset.
  assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr[ASIZE-1:0]];
  assign o_level   = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/can_rx_packer.sv
// can_rx_packer
//   Packs an unbuffered CAN RX byte stream into 32-bit words: one header word
//   followed by one or two data words per frame, queued in a show-ahead FIFO.
//   Frames that are oversize, do not fit, or arrive while a commit is busy
//   are dropped whole and counted.
//   Ports:
//     clk, rstn                         clock, async active-low reset
//     in_valid/in_last/in_data          byte stream, in_last on a frame's final byte
//     in_id/in_ide                      identifier and IDE flag, latched on first byte
//     out_valid/out_ready               head word handshake
//     out_data/out_keep/out_hdr/out_last head word, byte mask, header flag, frame end
//     fifo_level                        entries stored
//     drop_cnt/drop_pulse               saturating drop count, one-cycle drop strobe
//
//   state | meaning
//   IDLE  | no commit in progress, may accept a frame
//   HDR   | writing header word
//   D0    | writing data bytes 0..3
//   D1    | writing data bytes 4..7 (only when n > 4)
module can_rx_packer
  import can_rx_packer_pkg::*;
#(
  parameter int ASIZE = 6
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           in_valid,
  input  logic           in_last,
  input  logic [7:0]     in_data,
  input  logic [28:0]    in_id,
  input  logic           in_ide,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [31:0]    out_data,
  output logic [3:0]     out_keep,
  output logic           out_hdr,
  output logic           out_last,
  output logic [ASIZE:0] fifo_level,
  output logic [15:0]    drop_cnt,
  output logic           drop_pulse
);

  localparam logic [ASIZE:0] DEPTH_L = (ASIZE+1)'(1 << ASIZE);
  localparam logic [ASIZE:0] NEED_SHORT = (ASIZE+1)'(2);
  localparam logic [ASIZE:0] NEED_LONG  = (ASIZE+1)'(3);

  // staging
  logic [3:0]  r_stg_cnt;
  logic [63:0] r_stg_bytes;
  logic [28:0] r_stg_id;
  logic        r_stg_ide;
  logic        r_stg_ovs;

  // commit
  cmt_state_t  r_state;
  logic [3:0]  r_cmt_cnt;
  logic [63:0] r_cmt_bytes;
  logic [28:0] r_cmt_id;
  logic        r_cmt_ide;
  logic [15:0] r_drop_cnt;
  logic        r_drop_pulse;

  logic              w_first;
  logic [28:0]       w_id;
  logic              w_ide;
  logic [3:0]        w_cnt;
  logic [63:0]       w_bytes;
  logic              w_ovs;
  logic              w_req;
  logic [ASIZE:0]    w_need;
  logic [ASIZE:0]    w_free;
  logic              w_accept;
  logic              w_drop;
  logic              w_wr_en;
  logic [FIFO_W-1:0] w_wr_data;
  logic [31:0]       w_hdr_word;
  logic              w_rd_valid;
  logic [FIFO_W-1:0] w_rd_data;
  logic [ASIZE:0]    w_level;

  // Staging content including the current byte, i.e. what a commit would see.
  assign w_first = (r_stg_cnt == 4'd0);

  always_comb begin
    w_id    = w_first ? in_id  : r_stg_id;
    w_ide   = w_first ? in_ide : r_stg_ide;
    w_cnt   = r_stg_cnt;
    w_bytes = r_stg_bytes;
    w_ovs   = r_stg_ovs;
    if (r_stg_cnt < 4'd8) begin
      w_bytes = r_stg_bytes | ({in_data, 56'd0} >> {r_stg_cnt[2:0], 3'b000});
      w_cnt   = r_stg_cnt + 4'd1;
    end else begin
      w_ovs = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stg_cnt   <= '0;
      r_stg_bytes <= '0;
      r_stg_id    <= '0;
      r_stg_ide   <= 1'b0;
      r_stg_ovs   <= 1'b0;
    end else if (in_valid) begin
      if (in_last) begin
        r_stg_cnt   <= '0;
        r_stg_bytes <= '0;
        r_stg_id    <= '0;
        r_stg_ide   <= 1'b0;
        r_stg_ovs   <= 1'b0;
      end else begin
        r_stg_cnt   <= w_cnt;
        r_stg_bytes <= w_bytes;
        r_stg_id    <= w_id;
        r_stg_ide   <= w_ide;
        r_stg_ovs   <= w_ovs;
      end
    end
  end

  // Level is only trusted while IDLE: no write is in flight then, and pops
  // during the commit can only free more space.
  assign w_req    = in_valid && in_last;
  assign w_need   = (w_cnt > 4'd4) ? NEED_LONG : NEED_SHORT;
  assign w_free   = DEPTH_L - w_level;
  assign w_accept = w_req && !w_ovs && (r_state == ST_IDLE) && (w_free >= w_need);
  assign w_drop   = w_req && !w_accept;

  // Commit registers are loaded only on accept so a frame rejected while
  // busy cannot disturb the commit in progress.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_cmt_cnt    <= '0;
      r_cmt_bytes  <= '0;
      r_cmt_id     <= '0;
      r_cmt_ide    <= 1'b0;
      r_drop_cnt   <= '0;
      r_drop_pulse <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state     <= ST_HDR;
            r_cmt_cnt   <= w_cnt;
            r_cmt_bytes <= w_bytes;
            r_cmt_id    <= w_id;
            r_cmt_ide   <= w_ide;
          end
        end
        ST_HDR:  r_state <= ST_D0;
        ST_D0:   r_state <= (r_cmt_cnt > 4'd4) ? ST_D1 : ST_IDLE;
        ST_D1:   r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      r_drop_pulse <= w_drop;
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    w_hdr_word = '0;
    w_hdr_word[HDR_IDE_BIT]           = r_cmt_ide;
    w_hdr_word[HDR_ID_MSB:HDR_ID_LSB] = r_cmt_id;
  end

  // One entry per non-IDLE cycle.
  always_comb begin
    w_wr_en   = (r_state != ST_IDLE);
    w_wr_data = '0;
    case (r_state)
      ST_HDR: w_wr_data = {1'b1, 1'b0, 4'b1111, w_hdr_word};
      ST_D0:  w_wr_data = {1'b0, (r_cmt_cnt <= 4'd4), keep_mask(r_cmt_cnt),
                           r_cmt_bytes[63:32]};
      ST_D1:  w_wr_data = {1'b0, 1'b1, keep_mask(r_cmt_cnt - 4'd4),
                           r_cmt_bytes[31:0]};
      default: w_wr_data = '0;
    endcase
  end

  can_rx_fifo #(
    .ASIZE (ASIZE)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .i_wr_en   (w_wr_en),
    .i_wr_data (w_wr_data),
    .i_rd_en   (out_ready),
    .o_valid   (w_rd_valid),
    .o_rd_data (w_rd_data),
    .o_level   (w_level)
  );

  assign out_valid  = w_rd_valid;
  assign out_data   = w_rd_data[31:0];
  assign out_keep   = w_rd_data[ENT_KEEP_MSB:ENT_KEEP_LSB];
  assign out_hdr    = w_rd_data[ENT_HDR_BIT];
  assign out_last   = w_rd_data[ENT_LAST_BIT];
  assign fifo_level = w_level;
  assign drop_cnt   = r_drop_cnt;
  assign drop_pulse = r_drop_pulse;

endmodule

// File: tb/tb_can_rx_packer.sv
module tb_can_rx_packer;

  localparam int ASIZE = 6;
  localparam int DEPTH = 1 << ASIZE;

  logic           clk;
  logic           rstn;
  logic           in_valid;
  logic           in_last;
  logic [7:0]     in_data;
  logic [28:0]    in_id;
  logic           in_ide;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    out_data;
  logic [3:0]     out_keep;
  logic           out_hdr;
  logic           out_last;
  logic [ASIZE:0] fifo_level;
  logic [15:0]    drop_cnt;
  logic           drop_pulse;

  can_rx_packer #(.ASIZE(ASIZE)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_data    (in_data),
    .in_id      (in_id),
    .in_ide     (in_ide),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_hdr    (out_hdr),
    .out_last   (out_last),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt),
    .drop_pulse (drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model. An entry is {hdr, last, keep[3:0], data[31:0]}.
  // m_fifo: words visible to the consumer; m_pend: words of an accepted frame
  // still to be written, one per cycle; m_bytes: the frame being received.
  logic [37:0] m_fifo[$];
  logic [37:0] m_pend[$];
  logic [7:0]  m_bytes[$];
  logic [28:0] m_id;
  logic        m_ide;
  bit          m_ovs;
  int          m_drop_cnt;
  bit          m_pulse;

  logic [7:0]  fb[10];

  task automatic m_clear();
    m_fifo.delete();
    m_pend.delete();
    m_bytes.delete();
    m_id = '0;
    m_ide = 1'b0;
    m_ovs = 0;
    m_drop_cnt = 0;
    m_pulse = 0;
  endtask

  task automatic m_update(input bit v, input bit l, input logic [7:0] d,
                          input logic [28:0] id, input bit ide, input bit rdy);
    bit pop, push, busy, drop;
    logic [37:0] wr;
    int n, nw, freec;
    logic [31:0] dw;
    logic [3:0] kp;
    pop  = rdy && (m_fifo.size() > 0);
    busy = (m_pend.size() > 0);
    push = 0;
    drop = 0;
    wr   = '0;
    if (busy) begin
      wr = m_pend.pop_front();
      push = 1;
    end
    if (v) begin
      if (m_bytes.size() == 0) begin
        m_id = id;
        m_ide = ide;
      end
      if (m_bytes.size() < 8) m_bytes.push_back(d);
      else m_ovs = 1;
      if (l) begin
        n = m_bytes.size();
        nw = (n + 3) / 4;
        freec = DEPTH - m_fifo.size();
        if (m_ovs || busy || freec < 1 + nw) begin
          drop = 1;
        end else begin
          m_pend.push_back({1'b1, 1'b0, 4'hF, m_ide, 2'b00, m_id});
          for (int k = 0; k < nw; k++) begin
            dw = '0;
            kp = '0;
            for (int b = 0; b < 4; b++) begin
              if (4*k + b < n) begin
                dw[31-8*b -: 8] = m_bytes[4*k + b];
                kp[3-b] = 1'b1;
              end
            end
            m_pend.push_back({1'b0, (k == nw - 1), kp, dw});
          end
        end
        m_bytes.delete();
        m_ovs = 0;
      end
    end
    if (pop) void'(m_fifo.pop_front());
    if (push) m_fifo.push_back(wr);
    m_pulse = drop;
    if (drop && m_drop_cnt < 65535) m_drop_cnt++;
  endtask

  task automatic check_outputs();
    logic [37:0] head;
    chk("valid", out_valid, m_fifo.size() > 0);
    if (m_fifo.size() > 0) begin
      head = m_fifo[0];
      chk("data", out_data, head[31:0]);
      chk("keep", out_keep, head[35:32]);
      chk("hdr",  out_hdr,  head[37]);
      chk("last", out_last, head[36]);
    end
    chk("level", fifo_level, m_fifo.size());
    chk("pulse", drop_pulse, m_pulse);
    chk("dcnt",  drop_cnt,   m_drop_cnt);
  endtask

  // rmode: 0 = ready low, 1 = ready high, 2 = random 50%.
  // Called at a negedge; drives for one cycle and checks at the next negedge.
  task automatic step(input bit v, input bit l, input logic [7:0] d,
                      input logic [28:0] id, input bit ide, input int rmode);
    bit rdy;
    rdy = (rmode == 2) ? bit'($urandom_range(0, 1)) : (rmode == 1);
    in_valid  = v;
    in_last   = l;
    in_data   = d;
    in_id     = id;
    in_ide    = ide;
    out_ready = rdy;
    m_update(v, l, d, id, ide, rdy);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int k, input int rmode);
    for (int i = 0; i < k; i++) step(0, 0, 8'h00, '0, 0, rmode);
  endtask

  task automatic send_frame(input logic [28:0] id, input bit ide, input int n, input int rmode);
    for (int i = 0; i < n; i++) step(1, (i == n - 1), fb[i], id, ide, rmode);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    in_valid = 0;
    in_last = 0;
    out_ready = 0;
    m_clear();
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data,  0);
    chk("rst_keep",  out_keep,  0);
    chk("rst_hdr",   out_hdr,   0);
    chk("rst_last",  out_last,  0);
    chk("rst_level", fifo_level, 0);
    chk("rst_dcnt",  drop_cnt,  0);
    chk("rst_pulse", drop_pulse, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    in_valid = 0;
    in_last = 0;
    in_data = '0;
    in_id = '0;
    in_ide = 0;
    out_ready = 0;
    @(negedge clk);
    do_reset();
    idle(2, 0);

    // Standard frame, with latency check.
    fb[0] = 8'hAA; fb[1] = 8'hBB; fb[2] = 8'hCC;
    send_frame(29'h123, 0, 3, 0);
    chk("lat_t1_valid", out_valid, 0);
    idle(1, 0);
    chk("lat_t2_valid", out_valid, 1);
    chk("std_hdr_word", out_data, 32'h0000_0123);
    chk("std_hdr_flag", out_hdr, 1);
    idle(2, 0);
    chk("std_hdr_stall", out_data, 32'h0000_0123);
    idle(1, 1);
    chk("std_d0_word", out_data, 32'hAABB_CC00);
    chk("std_d0_keep", out_keep, 4'b1110);
    chk("std_d0_last", out_last, 1);
    idle(2, 1);

    // Extended 8-byte frame.
    for (int i = 0; i < 8; i++) fb[i] = 8'(i + 1);
    send_frame(29'h1ABC_DEF0, 1, 8, 0);
    idle(4, 0);
    chk("ext_hdr_word", out_data, 32'h9ABC_DEF0);
    idle(1, 1);
    chk("ext_d0_word", out_data, 32'h0102_0304);
    chk("ext_d0_keep", out_keep, 4'b1111);
    chk("ext_d0_last", out_last, 0);
    idle(1, 1);
    chk("ext_d1_word", out_data, 32'h0506_0708);
    chk("ext_d1_last", out_last, 1);
    idle(2, 1);

    // Fill to 62 entries, then a frame that does not fit.
    for (int f = 0; f < 20; f++) begin
      send_frame(29'(f), 0, 8, 0);
      idle(4, 0);
    end
    send_frame(29'h55, 0, 1, 0);
    idle(3, 0);
    chk("fill_level", fifo_level, 62);
    send_frame(29'h66, 1, 8, 0);
    chk("full_pulse", drop_pulse, 1);
    chk("full_dcnt", drop_cnt, 1);
    idle(1, 0);
    chk("full_pulse_end", drop_pulse, 0);
    idle(3, 0);
    chk("full_level_kept", fifo_level, 62);
    idle(70, 1);
    chk("drain_level", fifo_level, 0);

    // Oversize frame, then a good one.
    for (int i = 0; i < 10; i++) fb[i] = 8'(8'h30 + i);
    send_frame(29'h77, 0, 10, 0);
    chk("ovs_pulse", drop_pulse, 1);
    chk("ovs_dcnt", drop_cnt, 2);
    idle(4, 0);
    chk("ovs_no_write", fifo_level, 0);
    fb[0] = 8'h11; fb[1] = 8'h22;
    send_frame(29'h7FF, 0, 2, 0);
    idle(3, 0);
    chk("post_ovs_hdr", out_data, 32'h0000_07FF);
    idle(1, 1);
    chk("post_ovs_d0", out_data, 32'h1122_0000);
    chk("post_ovs_keep", out_keep, 4'b1100);
    idle(2, 1);

    // Reset mid-frame, then a 1-byte frame.
    fb[0] = 8'h01; fb[1] = 8'h02;
    step(1, 0, fb[0], 29'h99, 0, 0);
    step(1, 0, fb[1], 29'h99, 0, 0);
    do_reset();
    fb[0] = 8'h5A;
    send_frame(29'h55, 0, 1, 0);
    idle(3, 0);
    chk("rst_frame_lvl", fifo_level, 2);
    chk("rst_frame_hdr", out_data, 32'h0000_0055);
    idle(1, 1);
    chk("rst_frame_d0", out_data, 32'h5A00_0000);
    chk("rst_frame_keep", out_keep, 4'b1000);
    chk("rst_frame_last", out_last, 1);
    idle(1, 1);
    chk("rst_frame_empty", out_valid, 0);

    // Random frames, random ready, random gaps and bubbles.
    for (int f = 0; f < 200; f++) begin
      int n;
      logic [28:0] id;
      bit ide;
      n = $urandom_range(1, 10);
      ide = bit'($urandom_range(0, 1));
      id = 29'($urandom);
      if (!ide) id = id & 29'h7FF;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1, 2);
        step(1, (i == n - 1), 8'($urandom), id, ide, 2);
      end
      idle($urandom_range(0, 4), 2);
    end
    idle(300, 1);
    chk("final_level", fifo_level, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
